// File: rtl/conv_psum_accum.sv
// Per-channel multiply-accumulate over one convolution window (KERNEL_TAPS taps).
// Emits three signed partial sums plus the window bias on a valid/ready output register.
//   state    | meaning
//   ST_FIRST | waiting for tap 0 of a window; the product loads the accumulator, bias_in is captured
//   ST_ACC   | taps 1..KERNEL_TAPS-1; the final tap loads the output register
module conv_psum_accum #(
    parameter int KERNEL_TAPS = 9,
    parameter int PIX_W       = 8,
    parameter int WGT_W       = 16,
    parameter int SUM_W       = 29
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PIX_W-1:0]        pix_r,
    input  logic [PIX_W-1:0]        pix_g,
    input  logic [PIX_W-1:0]        pix_b,
    input  logic signed [WGT_W-1:0] wgt_r,
    input  logic signed [WGT_W-1:0] wgt_g,
    input  logic signed [WGT_W-1:0] wgt_b,
    input  logic signed [WGT_W-1:0] bias_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [SUM_W-1:0] add_outR,
    output logic signed [SUM_W-1:0] add_outG,
    output logic signed [SUM_W-1:0] add_outB,
    output logic signed [WGT_W-1:0] bias_out
);

    localparam int CNT_W = $clog2(KERNEL_TAPS);
    localparam int PRD_W = PIX_W + WGT_W + 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(KERNEL_TAPS - 1);

    typedef enum logic {ST_FIRST, ST_ACC} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        tap_cnt, cnt_nxt;
    logic signed [SUM_W-1:0] acc_r, acc_g, acc_b;
    logic signed [SUM_W-1:0] acc_r_nxt, acc_g_nxt, acc_b_nxt;
    logic signed [SUM_W-1:0] prod_r, prod_g, prod_b;
    logic signed [SUM_W-1:0] sum_r, sum_g, sum_b;
    logic signed [WGT_W-1:0] bias_cap, bias_cap_nxt;
    logic                    is_last, accept, load_out;

    // Unsigned pixel times signed weight, computed at full product width then sign-extended.
    function automatic logic signed [SUM_W-1:0] ext_prod(
        input logic [PIX_W-1:0]        p,
        input logic signed [WGT_W-1:0] w
    );
        logic signed [PRD_W-1:0] p_ext, w_ext, prod;
        p_ext = {{(WGT_W+1){1'b0}}, p};
        w_ext = {{(PIX_W+1){w[WGT_W-1]}}, w};
        prod  = p_ext * w_ext;
        return {{(SUM_W-PRD_W){prod[PRD_W-1]}}, prod};
    endfunction

    assign prod_r = ext_prod(pix_r, wgt_r);
    assign prod_g = ext_prod(pix_g, wgt_g);
    assign prod_b = ext_prod(pix_b, wgt_b);
    assign sum_r  = acc_r + prod_r;
    assign sum_g  = acc_g + prod_g;
    assign sum_b  = acc_b + prod_b;

    // Only the final tap can stall, and only while the previous result is still unclaimed.
    assign is_last  = (tap_cnt == LAST_TAP);
    assign in_ready = !(is_last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = tap_cnt;
        acc_r_nxt    = acc_r;
        acc_g_nxt    = acc_g;
        acc_b_nxt    = acc_b;
        bias_cap_nxt = bias_cap;
        load_out     = 1'b0;
        if (flush) begin
            state_nxt = ST_FIRST;
            cnt_nxt   = '0;
        end else if (accept) begin
            case (state)
                ST_FIRST: begin
                    acc_r_nxt    = prod_r;
                    acc_g_nxt    = prod_g;
                    acc_b_nxt    = prod_b;
                    bias_cap_nxt = bias_in;
                    cnt_nxt      = CNT_W'(1);
                    state_nxt    = ST_ACC;
                end
                ST_ACC: begin
                    if (is_last) begin
                        load_out  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_FIRST;
                    end else begin
                        acc_r_nxt = sum_r;
                        acc_g_nxt = sum_g;
                        acc_b_nxt = sum_b;
                        cnt_nxt   = tap_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_FIRST;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FIRST;
            tap_cnt  <= '0;
            acc_r    <= '0;
            acc_g    <= '0;
            acc_b    <= '0;
            bias_cap <= '0;
        end else begin
            state    <= state_nxt;
            tap_cnt  <= cnt_nxt;
            acc_r    <= acc_r_nxt;
            acc_g    <= acc_g_nxt;
            acc_b    <= acc_b_nxt;
            bias_cap <= bias_cap_nxt;
        end
    end

    // A result loading on the same edge as a consume keeps out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            add_outR  <= '0;
            add_outG  <= '0;
            add_outB  <= '0;
            bias_out  <= '0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            add_outR  <= sum_r;
            add_outG  <= sum_g;
            add_outB  <= sum_b;
            bias_out  <= bias_cap;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_psum_accum.sv
// Directed bench for conv_psum_accum: a window-level reference model checked every cycle,
// plus literal expectations for the individual test scenarios.
module tb_conv_psum_accum;

    localparam int K     = 9;
    localparam int PIX_W = 8;
    localparam int WGT_W = 16;
    localparam int SUM_W = 29;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid;
    logic [PIX_W-1:0] pix_r = '0, pix_g = '0, pix_b = '0;
    logic signed [WGT_W-1:0] wgt_r = '0, wgt_g = '0, wgt_b = '0, bias_in = '0;
    logic signed [SUM_W-1:0] add_outR, add_outG, add_outB;
    logic signed [WGT_W-1:0] bias_out;

    int n_checks = 0;
    int n_fail = 0;

    conv_psum_accum #(.KERNEL_TAPS(K), .PIX_W(PIX_W), .WGT_W(WGT_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .wgt_r(wgt_r), .wgt_g(wgt_g), .wgt_b(wgt_b),
        .bias_in(bias_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .add_outR(add_outR), .add_outG(add_outG), .add_outB(add_outB),
        .bias_out(bias_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Window-level model: taps in the current window, running sums, and the held result.
    int     m_cnt = 0;
    longint m_acc [3] = '{0, 0, 0};
    longint m_out [3] = '{0, 0, 0};
    longint m_bias = 0;
    longint m_bias_out = 0;
    bit     m_valid = 1'b0;

    function automatic bit m_ready();
        return !(m_cnt == K - 1 && m_valid && !out_ready);
    endfunction

    task automatic model_step();
        longint p [3];
        bit consume, load;
        if (!rst_n) begin
            m_cnt = 0;
            m_acc = '{0, 0, 0};
            m_out = '{0, 0, 0};
            m_bias = 0;
            m_bias_out = 0;
            m_valid = 1'b0;
        end else begin
            consume = m_valid && out_ready;
            load = 1'b0;
            if (flush) begin
                m_cnt = 0;
            end else if (in_valid && m_ready()) begin
                p[0] = longint'(pix_r) * longint'(wgt_r);
                p[1] = longint'(pix_g) * longint'(wgt_g);
                p[2] = longint'(pix_b) * longint'(wgt_b);
                for (int c = 0; c < 3; c++)
                    m_acc[c] = (m_cnt == 0) ? p[c] : m_acc[c] + p[c];
                if (m_cnt == 0) m_bias = longint'(bias_in);
                m_cnt++;
                if (m_cnt == K) begin
                    m_out = m_acc;
                    m_bias_out = m_bias;
                    m_cnt = 0;
                    load = 1'b1;
                end
            end
            if (load) m_valid = 1'b1;
            else if (consume) m_valid = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    task automatic compare_outputs();
        check("in_ready", longint'(in_ready), longint'(m_ready()));
        check("out_valid", longint'(out_valid), longint'(m_valid));
        check("add_outR", longint'(add_outR), m_out[0]);
        check("add_outG", longint'(add_outG), m_out[1]);
        check("add_outB", longint'(add_outB), m_out[2]);
        check("bias_out", longint'(bias_out), m_bias_out);
    endtask

    always @(negedge clk) compare_outputs();

    // Back-to-back phase monitor
    bit b2b_on = 1'b0;
    int ov_cnt = 0;
    int ir_drops = 0;
    always @(negedge clk) begin
        if (b2b_on) begin
            if (out_valid) begin
                ov_cnt++;
                check("b2b_sumR", longint'(add_outR), 36);
                check("b2b_sumG", longint'(add_outG), 72);
                check("b2b_sumB", longint'(add_outB), -36);
            end
            if (!in_ready) ir_drops++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tap(input int pr, input int pg, input int pb,
                           input int wr, input int wg, input int wb, input int b);
        pix_r = 8'(pr);   pix_g = 8'(pg);   pix_b = 8'(pb);
        wgt_r = 16'(wr);  wgt_g = 16'(wg);  wgt_b = 16'(wb);
        bias_in = 16'(b);
    endtask

    task automatic send_tap(input int pr, input int pg, input int pb,
                            input int wr, input int wg, input int wb, input int b);
        bit accepted;
        accepted = 1'b0;
        set_tap(pr, pg, pb, wr, wg, wb, b);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_ready && !flush;
            @(posedge clk);
            #1;
        end
        if (!accepted) check("tap_timeout", 0, 1);
    endtask

    task automatic wait_out(input string name, input longint er, input longint eg,
                            input longint eb, input longint ebias);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = out_valid;
        end
        check({name, "_valid"}, longint'(found), 1);
        if (found) begin
            check({name, "_R"}, longint'(add_outR), er);
            check({name, "_G"}, longint'(add_outG), eg);
            check({name, "_B"}, longint'(add_outB), eb);
            check({name, "_bias"}, longint'(bias_out), ebias);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_sumR", longint'(add_outR), 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Basic window
        for (int t = 0; t < K; t++) send_tap(10, 10, 10, 1, 2, -1, (t == 0) ? 5 : 99);
        in_valid = 1'b0;
        wait_out("basic", 90, 180, -90, 5);
        step();

        // Extreme products
        for (int t = 0; t < K; t++) send_tap(255, 255, 255, -32768, -32768, -32768, -1);
        in_valid = 1'b0;
        wait_out("ext_neg", -75202560, -75202560, -75202560, -1);
        step();
        for (int t = 0; t < K; t++) send_tap(255, 255, 255, 32767, 32767, 32767, 32767);
        in_valid = 1'b0;
        wait_out("ext_pos", 75200265, 75200265, 75200265, 32767);
        step();

        // Backpressure: first result waits while the next window fills
        out_ready = 1'b0;
        for (int t = 0; t < K; t++) send_tap(1, 1, 1, 1, 1, 1, 7);
        in_valid = 1'b0;
        wait_out("bp_first", 9, 9, 9, 7);
        step();
        for (int t = 0; t < K - 1; t++) send_tap(2, 2, 2, 1, 1, 1, 8);
        set_tap(2, 2, 2, 1, 1, 1, 8);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_stall_ready", longint'(in_ready), 0);
            check("bp_hold_valid", longint'(out_valid), 1);
            check("bp_hold_R", longint'(add_outR), 9);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", longint'(in_ready), 1);
        step();
        out_ready = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_valid", longint'(out_valid), 1);
        check("bp_second_R", longint'(add_outR), 18);
        check("bp_second_bias", longint'(bias_out), 8);
        step();
        out_ready = 1'b1;
        repeat (2) step();

        // Back-to-back windows
        b2b_on = 1'b1;
        for (int w = 0; w < 4; w++)
            for (int t = 0; t < K; t++) send_tap(t, t, t, 1, 2, -1, w);
        in_valid = 1'b0;
        repeat (3) step();
        b2b_on = 1'b0;
        check("b2b_out_count", longint'(ov_cnt), 4);
        check("b2b_ready_drops", longint'(ir_drops), 0);

        // Flush mid-window, with a tap presented in the flush cycle
        for (int t = 0; t < 5; t++) send_tap(7, 7, 7, 5, 5, 5, 1);
        set_tap(7, 7, 7, 5, 5, 5, 1);
        in_valid = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int t = 0; t < K; t++) send_tap(1, 1, 1, 3, 3, 3, (t == 0) ? 11 : 0);
        in_valid = 1'b0;
        wait_out("flush", 27, 27, 27, 11);
        step();

        // Asynchronous reset mid-window while a result is held
        out_ready = 1'b0;
        for (int t = 0; t < K; t++) send_tap(4, 4, 4, 1, 1, 1, 2);
        in_valid = 1'b0;
        wait_out("pre_rst", 36, 36, 36, 2);
        step();
        for (int t = 0; t < 4; t++) send_tap(5, 5, 5, 1, 1, 1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", longint'(out_valid), 0);
        check("async_rst_R", longint'(add_outR), 0);
        check("async_rst_G", longint'(add_outG), 0);
        check("async_rst_B", longint'(add_outB), 0);
        check("async_rst_bias", longint'(bias_out), 0);
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < K; t++) send_tap(3, 3, 3, 2, -4, 7, (t == 0) ? -3 : 50);
        in_valid = 1'b0;
        wait_out("post_rst", 54, -108, 189, -3);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
